// File: rtl/core_dmem_pkg.sv
// Shared types and constants for the core data-memory responder.
// Latency: none (package only).
// Backpressure: none (package only).
// Contents: dm_state_t access FSM states, WORD_BYTES lanes per access,
//           LFSR_TAPS feedback mask (bits 15,13,12,10 = taps 16,14,13,11).
package core_dmem_pkg;

    typedef enum logic [1:0] {
        DM_IDLE,
        DM_WAIT,
        DM_DONE
    } dm_state_t;

    localparam int          WORD_BYTES = 4;
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;

endpackage

// File: rtl/dmem_lfsr.sv
// 16-bit Fibonacci LFSR used to randomise data-memory stall lengths.
// Latency: new state every clk; the seed is loaded asynchronously on reset.
// Backpressure: none, free-running.
// Ports: clk, reset (async, active-high), o_state = current 16-bit state.
// Only compiled when DMEM_RAND_STALL_EN is defined.
`ifdef DMEM_RAND_STALL_EN
module dmem_lfsr
    import core_dmem_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1   // must be nonzero or the LFSR locks up
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] o_state
);

    logic [15:0] r_state;
    logic        w_fb;

    // XOR of the tapped bits, shifted in at the bottom.
    assign w_fb = ^(r_state & LFSR_TAPS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= SEED;
        end else begin
            r_state <= {r_state[14:0], w_fb};
        end
    end

    assign o_state = r_state;

endmodule
`endif

// File: rtl/core_dmem_model.sv
// Byte-addressable data-memory responder for the RV32I core data port.
// Latency: S stall cycles per access (S = WAIT_CYC, plus 0..3 when DMEM_RAND_STALL_EN is defined).
// Backpressure: data_stall=1 while the access is pending; the core must hold its request.
// Ports: req_mem/wmem_i/wmask_i/addr_i/wdata_i request in; rdata_o/data_stall/data_err
//        response out; rd_cnt/wr_cnt/err_cnt saturating completion counters.
// Optional feature macro: DMEM_RAND_STALL_EN (LFSR-driven extra stall cycles).
module core_dmem_model
    import core_dmem_pkg::*;
#(
    parameter int          ADDR_W    = 12,
    parameter int          WAIT_CYC  = 1,
    parameter int          CNT_W     = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_mem,
    input  logic             wmem_i,
    input  logic [3:0]       wmask_i,
    input  logic [31:0]      addr_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o,
    output logic             data_stall,
    output logic             data_err,
    output logic [CNT_W-1:0] rd_cnt,
    output logic [CNT_W-1:0] wr_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [7:0]        r_mem [DEPTH];
    dm_state_t         r_state;
    logic [15:0]       r_cnt;

    logic [1:0]        w_extra;
    logic [15:0]       w_stall_len;
    logic              w_oor;
    logic              w_start_zero;
    logic              w_complete;
    logic              w_commit;
    logic [ADDR_W-1:0] w_lane_addr [WORD_BYTES];
    logic [31:0]       w_rd_word;

`ifdef DMEM_RAND_STALL_EN
    logic [15:0] w_lfsr;
    logic [13:0] w_unused_lfsr;

    dmem_lfsr #(
        .SEED    (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .o_state (w_lfsr)
    );

    // Only the two low bits pick the extra stall.
    assign w_extra       = w_lfsr[1:0];
    assign w_unused_lfsr = w_lfsr[15:2];
`else
    logic [15:0] w_unused_seed;

    assign w_extra       = 2'b00;
    assign w_unused_seed = LFSR_SEED;
`endif

    // Stall length is evaluated in IDLE, i.e. at the start of each access.
    assign w_stall_len = 16'(WAIT_CYC) + {14'd0, w_extra};

    assign w_oor = |addr_i[31:ADDR_W];

    // Lane k is byte a+k; the adder width makes the wrap modulo the depth.
    always_comb begin
        w_rd_word = '0;
        for (int k = 0; k < WORD_BYTES; k++) begin
            w_lane_addr[k]      = addr_i[ADDR_W-1:0] + ADDR_W'(k);
            w_rd_word[8*k +: 8] = r_mem[w_lane_addr[k]];
        end
    end

    // Zero-stall accesses complete in IDLE without ever leaving it.
    assign w_start_zero = req_mem && (r_state == DM_IDLE) && (w_stall_len == 16'd0);
    assign w_complete   = req_mem && ((r_state == DM_DONE) || w_start_zero);
    assign w_commit     = w_complete && wmem_i && !w_oor;

    assign data_stall = req_mem && (((r_state == DM_IDLE) && (w_stall_len != 16'd0)) ||
                                    (r_state == DM_WAIT));
    assign data_err   = w_complete && w_oor;
    assign rdata_o    = (req_mem && !w_oor) ? w_rd_word : 32'd0;

    // The IDLE cycle is the first stall cycle, so WAIT lasts S-1 cycles:
    // the counter is loaded with S-1 and WAIT exits as it reaches zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= DM_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                DM_IDLE: begin
                    if (req_mem && (w_stall_len != 16'd0)) begin
                        r_cnt   <= w_stall_len - 16'd1;
                        r_state <= (w_stall_len == 16'd1) ? DM_DONE : DM_WAIT;
                    end
                end
                DM_WAIT: begin
                    if (!req_mem) begin
                        r_state <= DM_IDLE;   // abandoned: nothing written or counted
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                        if (r_cnt == 16'd1) begin
                            r_state <= DM_DONE;
                        end
                    end
                end
                DM_DONE: begin
                    r_state <= DM_IDLE;
                end
                default: begin
                    r_state <= DM_IDLE;
                end
            endcase
        end
    end

    // Reset restores the identity pattern byte[i] = i[7:0].
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 8'(i);
            end
        end else if (w_commit) begin
            for (int k = 0; k < WORD_BYTES; k++) begin
                if (wmask_i[k]) begin
                    r_mem[w_lane_addr[k]] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    // A write with an empty mask still counts as a good write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_cnt  <= '0;
            wr_cnt  <= '0;
            err_cnt <= '0;
        end else if (w_complete) begin
            if (w_oor) begin
                if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
            end else if (wmem_i) begin
                if (wr_cnt != '1) wr_cnt <= wr_cnt + CNT_W'(1);
            end else begin
                if (rd_cnt != '1) rd_cnt <= rd_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_core_dmem_model.sv
// Testbench for core_dmem_model: three instances (WAIT_CYC 0, 2, 1; the last with
// 2-bit counters) checked every cycle against a byte-array model, plus directed
// literal expectations.
module tb_core_dmem_model;

    localparam int AW    = 12;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        req   [3];
    logic        wmem  [3];
    logic [3:0]  wmask [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];
    logic        stall [3];
    logic        err   [3];

    logic [15:0] rdc0, wrc0, erc0, rdc1, wrc1, erc1;
    logic [1:0]  rdc2, wrc2, erc2;

    core_dmem_model #(.ADDR_W(AW), .WAIT_CYC(0), .CNT_W(16), .LFSR_SEED(16'hACE1)) u_dut0 (
        .clk(clk), .reset(reset), .req_mem(req[0]), .wmem_i(wmem[0]), .wmask_i(wmask[0]),
        .addr_i(addr[0]), .wdata_i(wdata[0]), .rdata_o(rdata[0]), .data_stall(stall[0]),
        .data_err(err[0]), .rd_cnt(rdc0), .wr_cnt(wrc0), .err_cnt(erc0));

    core_dmem_model #(.ADDR_W(AW), .WAIT_CYC(2), .CNT_W(16), .LFSR_SEED(16'hACE1)) u_dut1 (
        .clk(clk), .reset(reset), .req_mem(req[1]), .wmem_i(wmem[1]), .wmask_i(wmask[1]),
        .addr_i(addr[1]), .wdata_i(wdata[1]), .rdata_o(rdata[1]), .data_stall(stall[1]),
        .data_err(err[1]), .rd_cnt(rdc1), .wr_cnt(wrc1), .err_cnt(erc1));

    core_dmem_model #(.ADDR_W(AW), .WAIT_CYC(1), .CNT_W(2), .LFSR_SEED(16'hACE1)) u_dut2 (
        .clk(clk), .reset(reset), .req_mem(req[2]), .wmem_i(wmem[2]), .wmask_i(wmask[2]),
        .addr_i(addr[2]), .wdata_i(wdata[2]), .rdata_o(rdata[2]), .data_stall(stall[2]),
        .data_err(err[2]), .rd_cnt(rdc2), .wr_cnt(wrc2), .err_cnt(erc2));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int wc(input int d);
        return (d == 0) ? 0 : (d == 1) ? 2 : 1;
    endfunction

    function automatic int cap(input int d);
        return (d == 2) ? 3 : 65535;
    endfunction

    // k: 0 = reads, 1 = writes, 2 = errors
    function automatic logic [15:0] dut_cnt(input int d, input int k);
        logic [15:0] v;
        v = '0;
        case (d)
            0: v = (k == 0) ? rdc0 : (k == 1) ? wrc0 : erc0;
            1: v = (k == 0) ? rdc1 : (k == 1) ? wrc1 : erc1;
            default: v = {14'd0, (k == 0) ? rdc2 : (k == 1) ? wrc2 : erc2};
        endcase
        return v;
    endfunction

    // ---------------- reference model ----------------
    logic [7:0] m_mem [3][DEPTH];
    int         m_cnt [3][3];
    bit         in_acc [3];
    int         exp_s  [3];
    int         seen_s [3];

`ifdef DMEM_RAND_STALL_EN
    logic [15:0] m_lfsr;
    always @(posedge clk or posedge reset) begin
        if (reset) m_lfsr <= 16'hACE1;
        else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
`endif

    task automatic model_complete(input int d);
        logic [31:0] exp_rd;
        logic        oor;
        int          a;
        oor = (addr[d][31:AW] != '0);
        a   = int'(addr[d][AW-1:0]);
        exp_rd = '0;
        if (!oor) begin
            for (int k = 0; k < 4; k++) exp_rd[8*k +: 8] = m_mem[d][(a + k) % DEPTH];
        end
        chk($sformatf("m%0d_rdata", d), rdata[d], exp_rd);
        chk($sformatf("m%0d_err", d), {31'd0, err[d]}, {31'd0, oor});
        chk($sformatf("m%0d_stall_len", d), 32'(seen_s[d]), 32'(exp_s[d]));
        if (oor) begin
            if (m_cnt[d][2] < cap(d)) m_cnt[d][2]++;
        end else if (wmem[d]) begin
            if (m_cnt[d][1] < cap(d)) m_cnt[d][1]++;
            for (int k = 0; k < 4; k++)
                if (wmask[d][k]) m_mem[d][(a + k) % DEPTH] = wdata[d][8*k +: 8];
        end else begin
            if (m_cnt[d][0] < cap(d)) m_cnt[d][0]++;
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            for (int d = 0; d < 3; d++) begin
                for (int i = 0; i < DEPTH; i++) m_mem[d][i] = 8'(i);
                for (int k = 0; k < 3; k++) m_cnt[d][k] = 0;
                in_acc[d] = 1'b0;
                seen_s[d] = 0;
            end
        end else begin
            for (int d = 0; d < 3; d++) begin
                for (int k = 0; k < 3; k++)
                    chk($sformatf("m%0d_cnt%0d", d, k), 32'(dut_cnt(d, k)), 32'(m_cnt[d][k]));
                if (!req[d]) begin
                    in_acc[d] = 1'b0;
                    chk($sformatf("m%0d_idle_stall", d), {31'd0, stall[d]}, 32'd0);
                    chk($sformatf("m%0d_idle_err", d), {31'd0, err[d]}, 32'd0);
                    chk($sformatf("m%0d_idle_rdata", d), rdata[d], 32'd0);
                end else begin
                    if (!in_acc[d]) begin
                        in_acc[d] = 1'b1;
                        seen_s[d] = 0;
`ifdef DMEM_RAND_STALL_EN
                        exp_s[d] = wc(d) + int'(m_lfsr[1:0]);
`else
                        exp_s[d] = wc(d);
`endif
                    end
                    if (stall[d]) begin
                        seen_s[d]++;
                        chk($sformatf("m%0d_err_in_stall", d), {31'd0, err[d]}, 32'd0);
                    end else begin
                        model_complete(d);
                        in_acc[d] = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_access(input int d, input logic w, input logic [3:0] m,
                             input logic [31:0] a, input logic [31:0] wd,
                             output logic [31:0] rd, output logic e, output int nst);
        bit done;
        @(posedge clk); #1;
        req[d] = 1'b1; wmem[d] = w; wmask[d] = m; addr[d] = a; wdata[d] = wd;
        nst = 0; done = 1'b0; rd = '0; e = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (stall[d]) nst++;
            else begin
                done = 1'b1; rd = rdata[d]; e = err[d];
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL timeout dut%0d addr %08h: still stalled after 20 cycles, required completion", d, a);
        end
    endtask

    task automatic idle(input int d);
        @(posedge clk); #1;
        req[d] = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required $finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        e;
        int          n;

        reset = 1'b1;
        for (int d = 0; d < 3; d++) begin
            req[d] = 1'b0; wmem[d] = 1'b0; wmask[d] = '0; addr[d] = '0; wdata[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_stall", {31'd0, stall[1]}, 32'd0);
        chk("rst_err", {31'd0, err[1]}, 32'd0);
        chk("rst_rd_cnt", 32'(rdc0), 32'd0);
        chk("rst_wr_cnt", 32'(wrc1), 32'd0);

        // 1. zero-wait read
        do_access(0, 1'b0, 4'h0, 32'h10, 32'h0, rd, e, n);
        chk("t1_rdata", rd, 32'h13121110);
`ifndef DMEM_RAND_STALL_EN
        chk("t1_stall_cycles", 32'(n), 32'd0);
`endif
        idle(0);
        @(negedge clk);
        chk("t1_rd_cnt", 32'(rdc0), 32'd1);

        // 2. masked write with two wait states
        do_access(1, 1'b1, 4'b0101, 32'h20, 32'hDEADBEEF, rd, e, n);
`ifndef DMEM_RAND_STALL_EN
        chk("t2_stall_cycles", 32'(n), 32'd2);
`endif
        idle(1);
        do_access(1, 1'b0, 4'h0, 32'h20, 32'h0, rd, e, n);
        chk("t2_rdata", rd, 32'h23AD21EF);
        // 3. wrap-around, back-to-back with another read
        do_access(1, 1'b0, 4'h0, 32'hFFE, 32'h0, rd, e, n);
        chk("t3_wrap_rdata", rd, 32'h0100FFFE);
        do_access(1, 1'b0, 4'h0, 32'h10, 32'h0, rd, e, n);
        chk("t3_b2b_rdata", rd, 32'h13121110);
        idle(1);
        @(negedge clk);
        chk("t2_wr_cnt", 32'(wrc1), 32'd1);
        chk("t3_rd_cnt", 32'(rdc1), 32'd3);

        // 4. out-of-range write
        do_access(1, 1'b1, 4'hF, 32'h0000_1004, 32'h11223344, rd, e, n);
        chk("t4_err", {31'd0, e}, 32'd1);
        chk("t4_rdata", rd, 32'd0);
        idle(1);
        do_access(1, 1'b0, 4'h0, 32'h4, 32'h0, rd, e, n);
        chk("t4_mem_unchanged", rd, 32'h07060504);
        idle(1);
        @(negedge clk);
        chk("t4_err_cnt", 32'(erc1), 32'd1);
        chk("t4_wr_cnt", 32'(wrc1), 32'd1);

        // empty-mask write still counts
        do_access(0, 1'b1, 4'h0, 32'h40, 32'hFFFFFFFF, rd, e, n);
        do_access(0, 1'b0, 4'h0, 32'h40, 32'h0, rd, e, n);
        chk("nomask_rdata", rd, 32'h43424140);
        idle(0);
        @(negedge clk);
        chk("nomask_wr_cnt", 32'(wrc0), 32'd1);

        // request dropped during WAIT: no write, no count
        @(posedge clk); #1;
        req[1] = 1'b1; wmem[1] = 1'b1; wmask[1] = 4'hF; addr[1] = 32'h50; wdata[1] = 32'hA5A5A5A5;
        @(negedge clk);
        chk("abandon_stall", {31'd0, stall[1]}, 32'd1);
        idle(1);
        do_access(1, 1'b0, 4'h0, 32'h50, 32'h0, rd, e, n);
        chk("abandon_rdata", rd, 32'h53525150);
        idle(1);
        @(negedge clk);
        chk("abandon_wr_cnt", 32'(wrc1), 32'd1);

        // counter saturation on the 2-bit instance
        for (int i = 0; i < 5; i++) begin
            do_access(2, 1'b0, 4'h0, 32'(32'h100 + 4 * i), 32'h0, rd, e, n);
            chk("sat_rdata", rd, {8'(32'h103 + 4 * i), 8'(32'h102 + 4 * i),
                                  8'(32'h101 + 4 * i), 8'(32'h100 + 4 * i)});
        end
        idle(2);
        @(negedge clk);
        chk("sat_rd_cnt", 32'(rdc2), 32'd3);

        // 5. reset in WAIT of a write
        @(posedge clk); #1;
        req[1] = 1'b1; wmem[1] = 1'b1; wmask[1] = 4'hF; addr[1] = 32'h30; wdata[1] = 32'hCAFEF00D;
        @(negedge clk);
        chk("t5_stall", {31'd0, stall[1]}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b1; req[1] = 1'b0;
        @(negedge clk);
        chk("t5_rst_rd_cnt", 32'(rdc1), 32'd0);
        chk("t5_rst_wr_cnt", 32'(wrc1), 32'd0);
        chk("t5_rst_err_cnt", 32'(erc1), 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        do_access(1, 1'b0, 4'h0, 32'h30, 32'h0, rd, e, n);
        chk("t5_rdata", rd, 32'h33323130);
        do_access(1, 1'b0, 4'h0, 32'h20, 32'h0, rd, e, n);
        chk("t5_reinit_rdata", rd, 32'h23222120);
        idle(1);

`ifdef DMEM_RAND_STALL_EN
        // 6. random stall: back-to-back reads, stall within WAIT_CYC..WAIT_CYC+3
        for (int i = 0; i < 8; i++) begin
            logic [31:0] a;
            a = 32'(i * 37 + 5);
            do_access(1, 1'b0, 4'h0, a, 32'h0, rd, e, n);
            checks++;
            if (n < 2 || n > 5) begin
                errors++;
                $display("FAIL t6_stall_range: got %0d cycles, required 2..5", n);
            end
            chk("t6_rdata", rd, {8'(a + 3), 8'(a + 2), 8'(a + 1), 8'(a)});
        end
        idle(1);
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
